trap_controller: RTL

Machine-mode trap sequencer for the single-cycle RV32I core. It sits beside the control unit, consuming its `IntCause`/`MRet` decode, the external interrupt line and the current PC. It owns the trap CSRs (mstatus, mie, mtvec, mepc, mcause, mip) and sequences trap entry and `mret` return as short multi-cycle redirects. While it does so, it stalls the PC and kills side effects of the affected instruction.

---
 rtl/trap_controller.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/trap_controller.sv
// Machine-mode trap sequencer for the single-cycle RV32I core.
// Owns mstatus/mie/mtvec/mepc/mcause/mip and turns an accepted trap or mret
// into a two-cycle redirect: the event cycle stalls and kills the instruction,
// and the following cycle kills the re-presented copy while the PC is loaded
// with the handler or return address.
module trap_controller #(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic        instr_valid,
    input  logic [1:0]  int_cause,
    input  logic        mret,
    input  logic        ext_int,
    input  logic [11:0] csr_addr,
    input  logic        csr_we,
    input  logic [31:0] csr_wdata,
    output logic [31:0] csr_rdata,
    output logic        stall,
    output logic        kill,
    output logic        redirect,
    output logic [31:0] redirect_pc
);

    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MIE     = 12'h304;
    localparam logic [11:0] ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
    localparam logic [11:0] ADDR_MIP     = 12'h344;

    localparam logic [31:0] CAUSE_EXT_IRQ = 32'h8000_000B;
    localparam logic [31:0] CAUSE_ILLEGAL = 32'd2;
    localparam logic [31:0] CAUSE_ECALL   = 32'd11;

    localparam logic [1:0] INT_ECALL = 2'd2;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        ENTER  = 2'd1,
        RETURN = 2'd2
    } state_t;

    state_t      state;

    // Architectural CSR state; only the implemented bits are kept.
    logic        mstatus_mie;
    logic        mstatus_mpie;
    logic        mie_meie;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic [31:0] mcause;

    // Event qualification for the current cycle.
    logic        in_run;
    logic        irq;
    logic        exc;
    logic        trap;
    logic        ret;
    logic        csr_write;
    logic [31:0] trap_cause;

    // Decide which event (if any) the current instruction raises, by priority.
    always_comb begin
        in_run     = (state == RUN);
        irq        = in_run & instr_valid & ext_int & mstatus_mie & mie_meie;
        exc        = in_run & instr_valid & (int_cause != 2'd0);
        trap       = irq | exc;
        ret        = in_run & instr_valid & mret & ~trap;
        csr_write  = in_run & instr_valid & csr_we & ~trap & ~mret;
        if (irq) begin
            trap_cause = CAUSE_EXT_IRQ;
        end else if (int_cause == INT_ECALL) begin
            trap_cause = CAUSE_ECALL;
        end else begin
            trap_cause = CAUSE_ILLEGAL;
        end
    end

    // Hold the PC during the event cycle; kill both the event cycle and the
    // re-presented instruction in the redirect cycle.
    always_comb begin
        stall = trap | ret;
        kill  = trap | ret | redirect;
    end

    // Combinational CSR read port; unimplemented addresses read as zero.
    always_comb begin
        csr_rdata = 32'h0000_0000;
        case (csr_addr)
            ADDR_MSTATUS: begin
                csr_rdata[3] = mstatus_mie;
                csr_rdata[7] = mstatus_mpie;
            end
            ADDR_MIE:    csr_rdata[11] = mie_meie;
            ADDR_MTVEC:  csr_rdata     = mtvec;
            ADDR_MEPC:   csr_rdata     = mepc;
            ADDR_MCAUSE: csr_rdata     = mcause;
            ADDR_MIP:    csr_rdata[11] = ext_int;
            default:     csr_rdata     = 32'h0000_0000;
        endcase
    end

    // Trap sequencer: CSR updates, state transitions and registered redirect.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RUN;
            mstatus_mie  <= 1'b0;
            mstatus_mpie <= 1'b0;
            mie_meie     <= 1'b0;
            mtvec        <= {MTVEC_RESET[31:2], 2'b00};
            mepc         <= 32'h0000_0000;
            mcause       <= 32'h0000_0000;
            redirect     <= 1'b0;
            redirect_pc  <= 32'h0000_0000;
        end else begin
            case (state)
                RUN: begin
                    if (trap) begin
                        mepc         <= {pc[31:2], 2'b00};
                        mcause       <= trap_cause;
                        mstatus_mpie <= mstatus_mie;
                        mstatus_mie  <= 1'b0;
                        redirect     <= 1'b1;
                        redirect_pc  <= mtvec;
                        state        <= ENTER;
                    end else if (ret) begin
                        // mstatus is restored on the way out of RETURN
                        redirect     <= 1'b1;
                        redirect_pc  <= mepc;
                        state        <= RETURN;
                    end else begin
                        redirect     <= 1'b0;
                        redirect_pc  <= 32'h0000_0000;
                        if (csr_write) begin
                            case (csr_addr)
                                ADDR_MSTATUS: begin
                                    mstatus_mie  <= csr_wdata[3];
                                    mstatus_mpie <= csr_wdata[7];
                                end
                                ADDR_MIE:    mie_meie <= csr_wdata[11];
                                ADDR_MTVEC:  mtvec    <= {csr_wdata[31:2], 2'b00};
                                ADDR_MEPC:   mepc     <= {csr_wdata[31:2], 2'b00};
                                ADDR_MCAUSE: mcause   <= csr_wdata;
                                default: ;
                            endcase
                        end
                    end
                end
                ENTER: begin
                    redirect    <= 1'b0;
                    redirect_pc <= 32'h0000_0000;
                    state       <= RUN;
                end
                RETURN: begin
                    mstatus_mie  <= mstatus_mpie;
                    mstatus_mpie <= 1'b1;
                    redirect     <= 1'b0;
                    redirect_pc  <= 32'h0000_0000;
                    state        <= RUN;
                end
                default: begin
                    redirect    <= 1'b0;
                    redirect_pc <= 32'h0000_0000;
                    state       <= RUN;
                end
            endcase
        end
    end

endmodule
